// File: rtl/demux41_pkg.sv
// Shared constants for the 1-to-4 lane deserializer: lane count, lane-pointer width
// and the EMPTY/FILLING encodings of the lane pointer.
package demux41_pkg;

    localparam int unsigned LANES = 4;
    localparam int unsigned SEL_W = 2;

    // SEL==0 is EMPTY; any non-zero SEL means FILLING
    typedef enum logic [SEL_W-1:0] {
        ST_EMPTY   = 2'd0,
        ST_FILLING = 2'd1
    } state_e;

    localparam logic [SEL_W-1:0] SEL_EMPTY = ST_EMPTY;
    localparam logic [SEL_W-1:0] SEL_LAST  = SEL_W'(LANES - 1);

endpackage

// File: rtl/demux41_out_reg.sv
// Valid/ready holding register for one assembled group: loads on request, holds
// while stalled, drops valid once the group has been taken.
module demux41_out_reg
    import demux41_pkg::*;
#(
    parameter int unsigned DW = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_i,
    input  logic [DW-1:0]    data_i,
    input  logic [LANES-1:0] mask_i,
    input  logic             rdy_i,
    output logic             vld_o,
    output logic [DW-1:0]    data_o,
    output logic [LANES-1:0] mask_o,
    output logic             ready_c_o
);

    logic             vld_q;
    logic [DW-1:0]    data_q;
    logic [LANES-1:0] mask_q;

    // Free slot, or the held group leaves on this edge
    assign ready_c_o = !vld_q || rdy_i;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            vld_q  <= 1'b0;
            data_q <= '0;
            mask_q <= '0;
        end else if (load_i) begin
            vld_q  <= 1'b1;
            data_q <= data_i;
            mask_q <= mask_i;
        end else if (rdy_i) begin
            vld_q  <= 1'b0;
        end
    end

    assign vld_o  = vld_q;
    assign data_o = data_q;
    assign mask_o = mask_q;

endmodule

// File: rtl/demux41_deser.sv
// Collects up to four W-bit lane words into one 4*W group, closing early on IN_LAST.
// Define DEMUX41_MSB_FIRST_EN to place lane 0 in the top W bits of OUT_DATA.
module demux41_deser
    import demux41_pkg::*;
#(
    parameter int unsigned W = 8
) (
    input  logic           CLK,
    input  logic           RST,
    input  logic           IN_VLD,
    output logic           IN_RDY,
    input  logic [W-1:0]   IN_DATA,
    input  logic           IN_LAST,
    output logic           OUT_VLD,
    input  logic           OUT_RDY,
    output logic [4*W-1:0] OUT_DATA,
    output logic [3:0]     OUT_MASK
);

    localparam int unsigned GW = LANES * W;

    logic [SEL_W-1:0] sel_q, sel_d;
    logic [W-1:0]     lane_q [LANES];
    logic [W-1:0]     lane_d [LANES];
    logic [LANES-1:0] mask_q, mask_d;
    logic [LANES-1:0] grp_mask;
    logic [GW-1:0]    grp_data;
    logic             in_xfer;
    logic             done;

    assign in_xfer = IN_VLD && IN_RDY;
    assign done    = in_xfer && ((sel_q == SEL_LAST) || IN_LAST);

    // Lane write and pointer advance; grp_mask includes the lane written this cycle
    always_comb begin
        sel_d    = sel_q;
        mask_d   = mask_q;
        lane_d   = lane_q;
        grp_mask = mask_q;
        if (in_xfer) begin
            lane_d[sel_q]   = IN_DATA;
            grp_mask[sel_q] = 1'b1;
            if (done) begin
                sel_d  = SEL_EMPTY;
                mask_d = '0;
            end else begin
                sel_d  = SEL_W'(sel_q + 1'b1);
                mask_d = grp_mask;
            end
        end
    end

    // Unwritten lanes read as zero so stale bytes never leak into a short group
    for (genvar k = 0; k < LANES; k++) begin : g_lane
`ifdef DEMUX41_MSB_FIRST_EN
        assign grp_data[(LANES-1-k)*W +: W] = grp_mask[k] ? lane_d[k] : '0;
`else
        assign grp_data[k*W +: W] = grp_mask[k] ? lane_d[k] : '0;
`endif
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            sel_q  <= SEL_EMPTY;
            mask_q <= '0;
            lane_q <= '{default: '0};
        end else begin
            sel_q  <= sel_d;
            mask_q <= mask_d;
            lane_q <= lane_d;
        end
    end

    demux41_out_reg #(
        .DW (GW)
    ) u_out_reg (
        .clk_i     (CLK),
        .rst_i     (RST),
        .load_i    (done),
        .data_i    (grp_data),
        .mask_i    (grp_mask),
        .rdy_i     (OUT_RDY),
        .vld_o     (OUT_VLD),
        .data_o    (OUT_DATA),
        .mask_o    (OUT_MASK),
        .ready_c_o (IN_RDY)
    );

endmodule

// File: tb/tb_demux41_deser.sv
// Self-checking bench for demux41_deser: directed group scenarios plus randomized
// traffic compared each cycle against a lane-list reference model.
module tb_demux41_deser;

    localparam int unsigned W  = 8;
    localparam int unsigned GW = 4 * W;

    logic          CLK;
    logic          RST;
    logic          IN_VLD;
    logic          IN_RDY;
    logic [W-1:0]  IN_DATA;
    logic          IN_LAST;
    logic          OUT_VLD;
    logic          OUT_RDY;
    logic [GW-1:0] OUT_DATA;
    logic [3:0]    OUT_MASK;

    int n_chk  = 0;
    int n_pass = 0;
    int cyc    = 0;

    logic [GW-1:0] obs_d[$];
    logic [3:0]    obs_m[$];
    int            obs_t[$];

    demux41_deser #(.W(W)) dut (
        .CLK      (CLK),
        .RST      (RST),
        .IN_VLD   (IN_VLD),
        .IN_RDY   (IN_RDY),
        .IN_DATA  (IN_DATA),
        .IN_LAST  (IN_LAST),
        .OUT_VLD  (OUT_VLD),
        .OUT_RDY  (OUT_RDY),
        .OUT_DATA (OUT_DATA),
        .OUT_MASK (OUT_MASK)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string nm, input logic [GW-1:0] act, input logic [GW-1:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
    endtask

    // Convert an lsb-first lane word (lane k at bits k*W) to the configured output order
    function automatic logic [GW-1:0] order(input logic [GW-1:0] v);
        logic [GW-1:0] r;
        r = v;
`ifdef DEMUX41_MSB_FIRST_EN
        for (int k = 0; k < 4; k++) r[(3-k)*W +: W] = v[k*W +: W];
`endif
        return r;
    endfunction

    function automatic logic [GW-1:0] pack(input logic [3:0][W-1:0] ln, input int cnt);
        logic [GW-1:0] r;
        r = '0;
        for (int k = 0; k < cnt; k++) r[k*W +: W] = ln[k];
        return order(r);
    endfunction

    // Reference model: a list of pending lanes and the group presented downstream
    logic             m_vld  = 1'b0;
    logic [GW-1:0]    m_data = '0;
    logic [3:0]       m_mask = '0;
    logic [3:0][W-1:0] m_ln  = '0;
    int               m_cnt  = 0;

    always @(posedge CLK or posedge RST) begin : mdl
        logic [3:0][W-1:0] nl;
        int nc;
        if (RST) begin
            m_vld <= 1'b0;
            m_cnt <= 0;
        end else begin
            if (m_vld && OUT_RDY) m_vld <= 1'b0;
            if (IN_VLD && (!m_vld || OUT_RDY)) begin
                nl = m_ln;
                nl[m_cnt] = IN_DATA;
                nc = m_cnt + 1;
                if (nc == 4 || IN_LAST) begin
                    m_vld  <= 1'b1;
                    m_data <= pack(nl, nc);
                    m_mask <= 4'((1 << nc) - 1);
                    m_cnt  <= 0;
                end else begin
                    m_ln  <= nl;
                    m_cnt <= nc;
                end
            end
        end
    end

    always @(negedge CLK) begin
        if (!RST) begin
            check("in_rdy", GW'(IN_RDY), GW'(!m_vld || OUT_RDY));
            check("out_vld", GW'(OUT_VLD), GW'(m_vld));
            if (m_vld) begin
                check("out_data", OUT_DATA, m_data);
                check("out_mask", GW'(OUT_MASK), GW'(m_mask));
            end
        end
    end

    always @(posedge CLK) begin
        cyc++;
        if (!RST && OUT_VLD && OUT_RDY) begin
            obs_d.push_back(OUT_DATA);
            obs_m.push_back(OUT_MASK);
            obs_t.push_back(cyc);
        end
    end

    task automatic send(input logic [W-1:0] d, input logic l);
        int  t;
        logic acc;
        t = 0;
        acc = 1'b0;
        IN_VLD  = 1'b1;
        IN_DATA = d;
        IN_LAST = l;
        while (!acc && t < 50) begin
            @(negedge CLK);
            acc = IN_RDY;
            @(posedge CLK);
            #1;
            t++;
        end
        check("send_accept", GW'(acc), GW'(1'b1));
        IN_VLD  = 1'b0;
        IN_LAST = 1'b0;
    endtask

    task automatic idle(input int n);
        IN_VLD  = 1'b0;
        IN_LAST = 1'b0;
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [GW-1:0] exp;
        RST = 1'b1; IN_VLD = 1'b0; IN_DATA = '0; IN_LAST = 1'b0; OUT_RDY = 1'b1;

        // Reset state
        @(negedge CLK);
        check("rst_vld", GW'(OUT_VLD), '0);
        check("rst_data", OUT_DATA, '0);
        check("rst_mask", GW'(OUT_MASK), '0);
        check("rst_in_rdy", GW'(IN_RDY), GW'(1'b1));
        @(posedge CLK); #1;
        RST = 1'b0;
        @(negedge CLK);
        check("post_rst_rdy", GW'(IN_RDY), GW'(1'b1));
        @(posedge CLK); #1;

        // Full group, one-cycle valid pulse
        send(8'h11, 1'b0); send(8'h22, 1'b0); send(8'h33, 1'b0); send(8'h44, 1'b0);
        check("g4_vld", GW'(OUT_VLD), GW'(1'b1));
        check("g4_data", OUT_DATA, order(32'h44332211));
        check("g4_mask", GW'(OUT_MASK), GW'(4'hF));
`ifdef DEMUX41_MSB_FIRST_EN
        check("msb_data", OUT_DATA, 32'h11223344);
`endif
        idle(1);
        check("g4_pulse", GW'(OUT_VLD), '0);

        // Early close and restart at lane 0
        send(8'hAA, 1'b0); send(8'hBB, 1'b1);
        check("last_data", OUT_DATA, order(32'h0000BBAA));
        check("last_mask", GW'(OUT_MASK), GW'(4'h3));
        send(8'hCC, 1'b1);
        check("lane0_vld", GW'(OUT_VLD), GW'(1'b1));
        check("lane0_data", OUT_DATA, order(32'h000000CC));
        check("lane0_mask", GW'(OUT_MASK), GW'(4'h1));
        idle(2);

        // Backpressure while the next group waits upstream
        obs_d.delete(); obs_m.delete(); obs_t.delete();
        OUT_RDY = 1'b0;
        send(8'h01, 1'b0); send(8'h02, 1'b0); send(8'h03, 1'b0); send(8'h04, 1'b0);
        IN_VLD = 1'b1; IN_DATA = 8'h55; IN_LAST = 1'b0;
        repeat (3) begin
            @(negedge CLK);
            check("hold_in_rdy", GW'(IN_RDY), '0);
            check("hold_vld", GW'(OUT_VLD), GW'(1'b1));
            check("hold_data", OUT_DATA, order(32'h04030201));
        end
        @(posedge CLK); #1;
        OUT_RDY = 1'b1;
        send(8'h55, 1'b0); send(8'h66, 1'b0); send(8'h77, 1'b0); send(8'h88, 1'b0);
        idle(2);
        check("bp_groups", GW'(obs_d.size()), GW'(2));
        if (obs_d.size() == 2) begin
            check("bp_g0", obs_d[0], order(32'h04030201));
            check("bp_g1", obs_d[1], order(32'h88776655));
            check("bp_g1_mask", GW'(obs_m[1]), GW'(4'hF));
        end

        // Asynchronous reset mid-group, between clock edges
        send(8'h9A, 1'b0); send(8'hBC, 1'b0);
        #1 RST = 1'b1;
        #1;
        check("arst_vld", GW'(OUT_VLD), '0);
        check("arst_data", OUT_DATA, '0);
        check("arst_mask", GW'(OUT_MASK), '0);
        check("arst_in_rdy", GW'(IN_RDY), GW'(1'b1));
        #1 RST = 1'b0;
        send(8'h01, 1'b0); send(8'h02, 1'b0); send(8'h03, 1'b0); send(8'h04, 1'b0);
        check("arst_next", OUT_DATA, order(32'h04030201));
        check("arst_next_mask", GW'(OUT_MASK), GW'(4'hF));
        idle(2);

        // Sixteen back-to-back bytes
        obs_d.delete(); obs_m.delete(); obs_t.delete();
        for (int i = 0; i < 16; i++) send(8'(8'h10 + i), 1'b0);
        idle(3);
        check("b2b_groups", GW'(obs_d.size()), GW'(4));
        if (obs_d.size() == 4) begin
            for (int g = 0; g < 4; g++) begin
                exp = '0;
                for (int k = 0; k < 4; k++) exp[k*W +: W] = 8'(8'h10 + 4*g + k);
                check("b2b_data", obs_d[g], order(exp));
                if (g > 0) check("b2b_gap", GW'(obs_t[g] - obs_t[g-1]), GW'(4));
            end
        end

        // Randomized traffic against the model
        repeat (600) begin
            IN_VLD  = ($urandom_range(0, 3) != 0);
            IN_DATA = W'($urandom);
            IN_LAST = ($urandom_range(0, 4) == 0);
            OUT_RDY = ($urandom_range(0, 3) != 0);
            @(posedge CLK); #1;
        end
        OUT_RDY = 1'b1;
        idle(4);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/demux41_deser.md
DEMUX41_DESER -- requirements
Module: demux41_deser

Interface
REQ-001 SHALL have parameter W, default 8: lane (byte) width in bits; legal range 1..32.
REQ-002 SHALL have port CLK, input, 1: single rising-edge clock for all state.
REQ-003 SHALL have port RST, input, 1: reset, asynchronous, active-high.
REQ-004 SHALL have port IN_VLD, input, 1: upstream lane word valid.
REQ-005 SHALL have port IN_RDY, output, 1: block accepts IN_DATA this cycle.
REQ-006 SHALL have port IN_DATA, input, W: lane word.
REQ-007 SHALL have port IN_LAST, input, 1: accepted lane word closes the current group early.
REQ-008 SHALL have port OUT_VLD, output, 1: assembled group valid.
REQ-009 SHALL have port OUT_RDY, input, 1: downstream accepts the group.
REQ-010 SHALL have port OUT_DATA, output, 4*W: assembled group, lanes 0..3.
REQ-011 SHALL have port OUT_MASK, output, 4: per-lane valid; lane k valid when bit k is set.

Function
REQ-012 SHALL define input transfer as IN_VLD&&IN_RDY and output transfer as OUT_VLD&&OUT_RDY, both sampled on the CLK rising edge.
REQ-013 SHALL drive IN_RDY combinationally as !OUT_VLD || OUT_RDY, with no path from IN_VLD or IN_LAST.
REQ-014 SHALL hold a 2-bit lane pointer SEL that acts as the state: SEL=0 is EMPTY, SEL=1..3 is FILLING.
REQ-015 SHALL write the accepted IN_DATA into assembly lane SEL, set assembly mask bit SEL, and increment SEL modulo 4.
REQ-016 SHALL treat a group as complete on the accepted lane word when SEL==3 or IN_LAST==1.
- On completion: assembly data and mask move to the output register with OUT_VLD=1 on the next edge (latency 1 cycle from the last lane).
- Also on completion: SEL returns to 0 and the assembly mask clears.
REQ-017 SHALL keep OUT_DATA, OUT_MASK and OUT_VLD stable while OUT_VLD&&!OUT_RDY.
REQ-018 SHALL, on simultaneous output transfer and completing input transfer, load the new group with OUT_VLD staying 1 and no bubble.
REQ-019 SHALL clear OUT_VLD after an output transfer when no new group completes in that cycle.
REQ-020 SHALL force unwritten lanes of a partial group to all-zero in OUT_DATA.
REQ-021 SHALL ignore IN_LAST when no input transfer occurs.
REQ-022 SHALL sustain one lane word per cycle while OUT_RDY is held 1.

Reset
REQ-023 SHALL on RST=1 immediately clear SEL, the assembly data and mask, OUT_VLD, OUT_DATA and OUT_MASK to 0, regardless of CLK.
REQ-024 SHALL discard any partial group when reset is asserted mid-operation.
REQ-025 SHALL drive IN_RDY=1 during and directly after reset.

Configuration
REQ-026 SHALL support macro DEMUX41_MSB_FIRST_EN.
- When defined: lane 0 occupies OUT_DATA[4W-1:3W] and lane k occupies [(4-k)W-1:(3-k)W]; OUT_MASK bit k still refers to lane k.
- When undefined: lane k occupies OUT_DATA[(k+1)W-1:kW].

Structure
REQ-027 SHALL place the lane count constant (4), the SEL width (2) and the EMPTY/FILLING state encodings in shared package demux41_pkg.
REQ-028 SHALL implement the output holding register as sub-module demux41_out_reg, which provides the valid/ready register stage with load and hold.

Verification
REQ-029 SHALL check: W=8, OUT_RDY=1, bytes 11,22,33,44 on consecutive cycles, then 1 cycle later -> OUT_DATA=44332211, OUT_MASK=F, OUT_VLD for exactly 1 cycle.
REQ-030 SHALL check: bytes AA,BB with IN_LAST on BB -> OUT_DATA=0000BBAA, OUT_MASK=3, and the next byte lands in lane 0.
REQ-031 SHALL check: OUT_RDY=0 with one group held and a second group in progress -> IN_RDY=0 and OUT_DATA stable; on OUT_RDY=1 the second group completes with no lost byte.
REQ-032 SHALL check: RST pulsed after 2 of 4 bytes -> all outputs 0 with no clock edge; the next 4 bytes 01..04 give 04030201.
REQ-033 SHALL check: 16 back-to-back bytes with OUT_RDY=1 -> 4 groups on consecutive OUT_VLD pulses, 4-cycle spacing, correct order.
REQ-034 SHALL check: DEMUX41_MSB_FIRST_EN defined, bytes 11,22,33,44 -> OUT_DATA=11223344, OUT_MASK=F.
